// File: rtl/mem_access_stage_pkg.sv
// Shared pipeline definitions for the memory-access stage: FSM encoding,
// default bus timeout, write-back select codes and address helpers.
package mem_access_stage_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int DEFAULT_TIMEOUT = 15;

    // RegDst selects which field names the destination register
    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

    // MemtoReg selects the write-back data source
    localparam logic [1:0] MEMTOREG_ALU = 2'd0;
    localparam logic [1:0] MEMTOREG_MEM = 2'd1;
    localparam logic [1:0] MEMTOREG_PC  = 2'd2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
    } mem_access_t;

    function automatic logic [31:0] word_align(input logic [31:0] byte_addr);
        return byte_addr & 32'hFFFF_FFFC;
    endfunction

    function automatic logic is_misaligned(input logic [31:0] byte_addr);
        return (byte_addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/mem_access_stage_timeout_counter.sv
// Counts bus wait cycles; expired is high during the last allowed wait cycle
// so the owner can leave BUSY on that same edge.
module mem_timeout_counter
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && !expired) begin
            count_reg <= count_reg + CW'(1);
        end
    end

    assign expired = (count_reg == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: passes EX/MEM fields to MEM/WB and runs a stalling
// IDLE/BUSY/DONE handshake with the data bus for loads and stores.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        validin,
    input  logic [4:0]  Rtin,
    input  logic [4:0]  Rdin,
    input  logic [31:0] PCplusin,
    input  logic [31:0] ALUresultin,
    input  logic [31:0] wdatain,
    input  logic        MemRdin,
    input  logic        MemWrin,
    input  logic [1:0]  RegDstin,
    input  logic        RegWrin,
    input  logic [1:0]  MemtoRegin,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [4:0]  Rtout,
    output logic [4:0]  Rdout,
    output logic [31:0] PCplusout,
    output logic [31:0] rdataout,
    output logic [31:0] ALUresultout,
    output logic [1:0]  RegDstout,
    output logic        RegWrout,
    output logic [1:0]  MemtoRegout,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err
);

    logic [1:0]   state_reg;
    logic [1:0]   state_next;
    mem_access_t  access_reg;
    logic [31:0]  rdata_reg;
    logic         err_reg;

    logic mem_op;
    logic bad_addr;
    logic start;
    logic in_busy;
    logic expired;

    assign mem_op   = validin & (MemRdin | MemWrin);
    assign bad_addr = is_misaligned(ALUresultin);
    assign start    = (state_reg == ST_IDLE) & mem_op & ~bad_addr;
    assign in_busy  = (state_reg == ST_BUSY);

    // Wait counter only runs in BUSY; any other state holds it cleared.
    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (~in_busy),
        .enable  (in_busy & ~mem_ack),
        .expired (expired)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_BUSY;
            ST_BUSY: if (mem_ack || expired) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            access_reg <= '0;
            rdata_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        access_reg.addr  <= ALUresultin;
                        access_reg.wdata <= wdatain;
                        access_reg.we    <= MemWrin;
                        err_reg          <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    // An ack on the expiring cycle still wins over the timeout.
                    if (mem_ack) begin
                        rdata_reg <= access_reg.we ? 32'd0 : mem_rdata;
                        err_reg   <= 1'b0;
                    end else if (expired) begin
                        rdata_reg <= 32'd0;
                        err_reg   <= 1'b1;
                    end
                end
                ST_DONE: err_reg <= 1'b0;
                default: err_reg <= 1'b0;
            endcase
        end
    end

    assign mem_req   = in_busy;
    assign mem_we    = in_busy & access_reg.we;
    assign mem_addr  = word_align(access_reg.addr);
    assign mem_wdata = access_reg.wdata;

    // Upstream registers are frozen by stall, so the inputs still describe
    // the same instruction when DONE forwards them.
    assign Rtout        = Rtin;
    assign Rdout        = Rdin;
    assign PCplusout    = PCplusin;
    assign ALUresultout = ALUresultin;
    assign RegDstout    = RegDstin;
    assign MemtoRegout  = MemtoRegin;

    always_comb begin
        stall    = 1'b0;
        misalign = 1'b0;
        bus_err  = 1'b0;
        RegWrout = 1'b0;
        rdataout = 32'd0;
        case (state_reg)
            ST_IDLE: begin
                if (!mem_op) begin
                    RegWrout = RegWrin & validin;
                end else if (bad_addr) begin
                    misalign = 1'b1;
                end else begin
                    stall = 1'b1;
                end
            end
            ST_BUSY: stall = 1'b1;
            ST_DONE: begin
                bus_err  = err_reg;
                RegWrout = RegWrin & ~err_reg;
                rdataout = rdata_reg;
            end
            default: stall = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a scoreboard queue holds the expected
// completion of each bus access and is checked when the stage reaches DONE.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        validin;
    logic [4:0]  Rtin, Rdin;
    logic [31:0] PCplusin, ALUresultin, wdatain;
    logic        MemRdin, MemWrin;
    logic [1:0]  RegDstin;
    logic        RegWrin;
    logic [1:0]  MemtoRegin;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [4:0]  Rtout, Rdout;
    logic [31:0] PCplusout, rdataout, ALUresultout;
    logic [1:0]  RegDstout;
    logic        RegWrout;
    logic [1:0]  MemtoRegout;
    logic        stall, misalign, bus_err;

    typedef struct {
        logic [31:0] rdata;
        logic        regwr;
        logic        berr;
        int          busy;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    mem_access_stage #(.TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .validin(validin),
        .Rtin(Rtin), .Rdin(Rdin), .PCplusin(PCplusin),
        .ALUresultin(ALUresultin), .wdatain(wdatain),
        .MemRdin(MemRdin), .MemWrin(MemWrin),
        .RegDstin(RegDstin), .RegWrin(RegWrin), .MemtoRegin(MemtoRegin),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .Rtout(Rtout), .Rdout(Rdout), .PCplusout(PCplusout),
        .rdataout(rdataout), .ALUresultout(ALUresultout),
        .RegDstout(RegDstout), .RegWrout(RegWrout), .MemtoRegout(MemtoRegout),
        .stall(stall), .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rd, input logic wr,
                         input logic [31:0] alu, input logic [31:0] wd, input logic rw);
        validin = v; MemRdin = rd; MemWrin = wr;
        ALUresultin = alu; wdatain = wd; RegWrin = rw;
    endtask

    // One bus access: IDLE cycle, BUSY cycles (ack in BUSY cycle ack_at), DONE.
    task automatic mem_op(input string name, input logic [31:0] addr, input logic [31:0] wd,
                          input logic st, input logic rw, input int ack_at,
                          input logic [31:0] rd, input logic [31:0] exp_rd,
                          input logic exp_rw, input logic exp_be, input int exp_busy);
        exp_t e;
        int   busy;
        bit   done;
        @(negedge clk);
        drive(1'b1, ~st, st, addr, wd, rw);
        e.rdata = exp_rd; e.regwr = exp_rw; e.berr = exp_be; e.busy = exp_busy;
        exp_q.push_back(e);
        #1;
        chk({name, "_idle_stall"}, 32'(stall), 32'd1);
        chk({name, "_idle_req"}, 32'(mem_req), 32'd0);
        busy = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            #1;
            if (stall === 1'b0) begin
                done = 1'b1;
            end else begin
                chk({name, "_busy_req"}, 32'(mem_req), 32'd1);
                if (busy == 0) begin
                    chk({name, "_busy_we"}, 32'(mem_we), 32'(st));
                    chk({name, "_busy_addr"}, mem_addr, addr & 32'hFFFF_FFFC);
                    chk({name, "_busy_wdata"}, mem_wdata, wd);
                    chk({name, "_busy_regwr"}, 32'(RegWrout), 32'd0);
                end
                if (busy == ack_at) begin
                    mem_ack = 1'b1;
                    mem_rdata = rd;
                end
                busy++;
            end
        end
        if (!done) chk({name, "_done_reached"}, 32'd0, 32'd1);
        e = exp_q.pop_front();
        chk({name, "_busy_cycles"}, 32'(busy), 32'(e.busy));
        chk({name, "_done_rdata"}, rdataout, e.rdata);
        chk({name, "_done_regwr"}, 32'(RegWrout), 32'(e.regwr));
        chk({name, "_done_buserr"}, 32'(bus_err), 32'(e.berr));
        chk({name, "_done_req"}, 32'(mem_req), 32'd0);
        @(negedge clk);
        mem_ack = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        #1;
        chk({name, "_after_stall"}, 32'(stall), 32'd0);
        chk({name, "_after_buserr"}, 32'(bus_err), 32'd0);
        $display("txn %s addr=%h busy=%0d rdata=%h regwr=%b bus_err=%b",
                 name, addr, busy, e.rdata, e.regwr, e.berr);
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        Rtin = 5'd3; Rdin = 5'd7; PCplusin = 32'h44;
        RegDstin = 2'd1; MemtoRegin = 2'd0;
        mem_rdata = 32'd0; mem_ack = 1'b0;
        #2;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_buserr", 32'(bus_err), 32'd0);
        chk("rst_rdata", rdataout, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // ALU op: same-cycle pass-through, no bus activity
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h10, 32'd0, 1'b1);
        #1;
        chk("alu_result", ALUresultout, 32'h10);
        chk("alu_regwr", 32'(RegWrout), 32'd1);
        chk("alu_rd", 32'(Rdout), 32'd7);
        chk("alu_pcplus", PCplusout, 32'h44);
        chk("alu_stall", 32'(stall), 32'd0);
        @(negedge clk);
        #1;
        chk("alu_req", 32'(mem_req), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h10, 32'd0, 1'b1);
        #1;
        chk("bubble_regwr", 32'(RegWrout), 32'd0);
        $display("txn alu result=%h regwr=%b", ALUresultout, RegWrout);

        mem_op("load100", 32'h100, 32'h0, 1'b0, 1'b1, 1, 32'hDEADBEEF,
               32'hDEADBEEF, 1'b1, 1'b0, 2);
        mem_op("store204", 32'h204, 32'h12345678, 1'b1, 1'b0, 0, 32'hFFFF_FFFF,
               32'h0, 1'b0, 1'b0, 1);
        mem_op("load_edge", 32'h400, 32'h0, 1'b0, 1'b1, 14, 32'hCAFEF00D,
               32'hCAFEF00D, 1'b1, 1'b0, 15);
        mem_op("load_to", 32'h500, 32'h0, 1'b0, 1'b1, 1000, 32'h1111_1111,
               32'h0, 1'b0, 1'b1, 15);

        // Misaligned load: exception pulse, no bus access, stays IDLE
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 32'h103, 32'd0, 1'b1);
        #1;
        chk("mis_pulse", 32'(misalign), 32'd1);
        chk("mis_regwr", 32'(RegWrout), 32'd0);
        chk("mis_stall", 32'(stall), 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        #1;
        chk("mis_req", 32'(mem_req), 32'd0);
        chk("mis_clear", 32'(misalign), 32'd0);
        $display("txn misalign addr=103");

        // Reset while BUSY abandons the access; a late ack is ignored
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 32'h300, 32'd0, 1'b1);
        @(negedge clk);
        #1;
        chk("rb_busy_req", 32'(mem_req), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rb_rst_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
        #1;
        chk("rb_ack_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("rb_idle_req", 32'(mem_req), 32'd0);
        chk("rb_idle_stall", 32'(stall), 32'd0);
        chk("rb_idle_rdata", rdataout, 32'd0);
        chk("rb_idle_buserr", 32'(bus_err), 32'd0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h20, 32'd0, 1'b1);
        #1;
        chk("rb_alu_regwr", 32'(RegWrout), 32'd1);
        chk("rb_alu_result", ALUresultout, 32'h20);
        $display("txn reset_in_busy addr=300");

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter: TIMEOUT, default 15, BUSY cycles without mem_ack before a bus error is declared.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 validin  in  1  EX/MEM slot holds a real instruction.
REQ-005 Rtin, Rdin  in  5 each  destination register candidates.
REQ-006 PCplusin  in  32  PC+4 of the instruction.
REQ-007 ALUresultin  in  32  ALU result; used as the memory byte address.
REQ-008 wdatain  in  32  store data.
REQ-009 MemRdin, MemWrin  in  1 each  load / store request.
REQ-010 RegDstin  in  2; RegWrin  in  1; MemtoRegin  in  2  write-back controls.
REQ-011 mem_req, mem_we  out  1 each  data bus request / write strobe.
REQ-012 mem_addr, mem_wdata  out  32 each  word-aligned bus address / store data.
REQ-013 mem_rdata  in  32; mem_ack  in  1  bus read data / completion.
REQ-014 Rtout, Rdout, PCplusout, rdataout, ALUresultout, RegDstout, RegWrout, MemtoRegout  out  widths as inputs  feed MEM/WB register.
REQ-015 stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle.
REQ-016 misalign, bus_err  out  1 each  one-cycle exception pulses.

Function
REQ-017 FSM states: IDLE, BUSY, DONE; a memory op means validin & (MemRdin | MemWrin).
REQ-018 IDLE, no memory op: combinational pass-through (Rt/Rd/PCplus/ALUresult/RegDst/MemtoReg unchanged), RegWrout = RegWrin & validin, rdataout = 0, stall = 0.
REQ-019 IDLE, memory op with ALUresultin[1:0] != 0: misalign = 1, no bus access, RegWrout = 0, stall = 0, stay IDLE.
REQ-020 IDLE, aligned memory op: stall = 1, RegWrout = 0, next state BUSY; latch address, wdata, and we = MemWrin.
REQ-021 BUSY: mem_req = 1, mem_we/mem_addr/mem_wdata driven from latched values, {addr[31:2],2'b00}; stall = 1, RegWrout = 0.
REQ-022 BUSY & mem_ack: capture mem_rdata into rdata_q (loads only; stores capture 0), next state DONE.
REQ-023 BUSY counter increments each cycle without mem_ack; when it reaches TIMEOUT: next state DONE, bus_err pulses in DONE, rdata_q = 0.
REQ-024 DONE: stall = 0, outputs pass-through from EX/MEM inputs (held by stall), rdataout = rdata_q, RegWrout = RegWrin & ~bus_err, next state IDLE.
REQ-025 Minimum memory-op latency: 3 cycles (IDLE, BUSY with ack, DONE); mem_req drops in the cycle after mem_ack.
REQ-026 mem_ack outside BUSY is ignored; mem_ack on the same cycle the counter hits TIMEOUT counts as success (no bus_err).
REQ-027 Inputs are assumed stable while stall = 1; block does not re-sample them in BUSY.

Reset
REQ-028 reset = 0 forces state IDLE, counter 0, rdata_q 0, latched addr/wdata/we 0, bus_err 0, immediately (asynchronous).
REQ-029 Reset during BUSY abandons the access: mem_req = 0 while reset is asserted; a late mem_ack is ignored.
REQ-030 After release, first rising edge behaves as IDLE.

Structure
REQ-031 Shared pipeline package holds FSM state encoding, default TIMEOUT, and MemtoReg/RegDst code constants.
REQ-032 One sub-module: mem_timeout_counter (clear, enable, expired output), instantiated once.

Verification
REQ-033 ALU op, ALUresultin=0x10, RegWrin=1 -> same-cycle pass-through, stall=0, mem_req never asserted.
REQ-034 Load at 0x100, mem_ack on 2nd BUSY cycle with rdata 0xDEADBEEF -> stall high 3 cycles, DONE rdataout=0xDEADBEEF, RegWrout=1.
REQ-035 Store at 0x204, wdata 0x12345678, immediate ack -> mem_we=1, mem_addr=0x204, mem_wdata=0x12345678, RegWrout=0 throughout.
REQ-036 Load at 0x103 -> misalign pulse, mem_req=0, RegWrout=0, stall=0.
REQ-037 Load, no ack -> bus_err after 15 BUSY cycles, rdataout=0, RegWrout=0, then IDLE.
REQ-038 reset=0 in BUSY, then ack -> mem_req=0 during reset, ack ignored, state IDLE.
